pwm_capture: RTL

Single-channel PWM input-capture block: the receive-side counterpart of the `pwm` generator. It samples an external PWM waveform arriving through an IO pad (`pad_pwm_dout`), measures the period and high time in prescaled ticks, and presents each completed measurement with a one-cycle valid strobe. It sits between the pad ring and the peripheral register interface, with one instance per monitored pad.

---
 rtl/pwm_capture.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: PWM period/high-time input capture; `PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample input filter
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] prescaler_i,
    input  logic             pwm_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             ovf_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic lvl, edge_q, rise, fall, tick;
    logic [CNT_W-1:0] cnt_q, cnt_d, hsh_q, hsh_d, psc_q, psc_d, lim_q, lim_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
    logic valid_q, valid_d, ovf_q, ovf_d;
    // Shift the asynchronous pad level through the synchronizer chain
    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], pwm_i};
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] hist_q, hist_d;
    logic filt_q, filt_d;
    // Filtered level follows the input only after 3 equal consecutive samples
    always_comb begin
        hist_d = {hist_q[0], sync_q[SYNC_STAGES-1]};
        filt_d = ({hist_q, sync_q[SYNC_STAGES-1]} == 3'b111) ? 1'b1 :
                 ({hist_q, sync_q[SYNC_STAGES-1]} == 3'b000) ? 1'b0 : filt_q;
    end
    // Filter history and filtered level registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end
    assign lvl = filt_q;
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif
    assign rise = lvl & ~edge_q;
    assign fall = ~lvl & edge_q;
    assign tick = (psc_q == lim_q);
    // Next-state, counter and result logic; overflow takes priority over edges
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hsh_d    = hsh_q;
        psc_d    = psc_q;
        lim_d    = lim_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        ovf_d    = clear_i ? 1'b0 : ovf_q;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_W'(1);
                        psc_d   = '0;
                        lim_d   = prescaler_i;
                    end
                end
                default: begin
                    psc_d = tick ? '0 : psc_q + CNT_W'(1);
                    if (tick && (&cnt_q)) begin
                        ovf_d   = 1'b1;
                        state_d = ARM;
                    end else begin
                        if (tick) cnt_d = cnt_q + CNT_W'(1);
                        if (state_q == HIGH && fall) begin
                            hsh_d   = cnt_q;
                            state_d = LOW;
                        end
                        if (state_q == LOW && rise) begin
                            period_d = cnt_q;
                            high_d   = hsh_q;
                            valid_d  = 1'b1;
                            state_d  = HIGH;
                            cnt_d    = CNT_W'(1);
                            psc_d    = '0;
                            lim_d    = prescaler_i;
                        end
                    end
                end
            endcase
        end
    end
    // State, counters and results with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            edge_q   <= 1'b0;
            cnt_q    <= '0;
            hsh_q    <= '0;
            psc_q    <= '0;
            lim_q    <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            edge_q   <= lvl;
            cnt_q    <= cnt_d;
            hsh_q    <= hsh_d;
            psc_q    <= psc_d;
            lim_q    <= lim_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end
    assign period_o = period_q;
    assign high_o   = high_q;
    assign valid_o  = valid_q;
    assign ovf_o    = ovf_q;
    assign busy_o   = (state_q == HIGH) || (state_q == LOW);
endmodule
